// File: rtl/demod_mul_sched_if.sv
// demod_mul_sched_if: sample inputs, history clears, multiplier operands/product
// and demodulated output of the shared-multiplier FM demodulator controller.
interface demod_mul_sched_if #(
  parameter int CHANNELS = 4,
  parameter int CW       = 3
);
  logic [CHANNELS-1:0]   in_valid;
  logic [CHANNELS-1:0]   in_ready;
  logic [8*CHANNELS-1:0] in_i;
  logic [8*CHANNELS-1:0] in_q;
  logic [CHANNELS-1:0]   hist_clr;
  logic signed [7:0]     mul_a;
  logic signed [7:0]     mul_b;
  logic signed [15:0]    mul_p;
  logic signed [15:0]    m;
  logic                  m_valid;
  logic [CW-1:0]         m_chan;

  // Controller side: consumes samples and the product, drives operands and result.
  modport slave (
    input  in_valid, in_i, in_q, hist_clr, mul_p,
    output in_ready, mul_a, mul_b, m, m_valid, m_chan
  );

  // Environment side: sample sources, multiplier and result sink.
  modport master (
    output in_valid, in_i, in_q, hist_clr, mul_p,
    input  in_ready, mul_a, mul_b, m, m_valid, m_chan
  );
endinterface

// File: rtl/demod_mul_sched.sv
// demod_mul_sched: time-multiplexed FM cross-product demodulator controller.
// One external 8x8 signed multiplier is shared round-robin among CHANNELS
// I/Q streams; each accepted sample takes two multiplier phases and yields
// m = I*Q_last - Q*I_last for its channel three cycles after the handshake.
module demod_mul_sched #(
  parameter int CHANNELS = 4,
  parameter int CW       = 3
) (
  input logic              clk,
  input logic              rst_n,
  demod_mul_sched_if.slave bus
);
  // History and arbiter lookups are padded to the full index range so every
  // CW-bit channel index addresses a real entry.
  localparam int NPAD = 2 ** CW;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL1 = 2'd1,
    MUL2 = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      ptr_q, ptr_d;
  logic [CW-1:0]      ch_q, ch_d;
  logic [CW-1:0]      mChan_q, mChan_d;
  logic signed [7:0]  iCap_q, iCap_d;
  logic signed [7:0]  qCap_q, qCap_d;
  logic signed [15:0] p1_q, p1_d;
  logic signed [15:0] m_q, m_d;
  logic               mValid_q, mValid_d;
  logic signed [7:0]  iLast_q [NPAD];
  logic signed [7:0]  qLast_q [NPAD];

  logic [NPAD-1:0]     validPad;
  logic [CW-1:0]       probe;
  logic [CW-1:0]       grantIdx;
  logic                grantValid;
  logic signed [7:0]   iSel, qSel;
  logic signed [7:0]   mulA, mulB;
  logic                histWr;
  logic [CHANNELS-1:0] readyVec;

  // Round-robin search from the channel after the last grant, plus sample mux.
  always_comb begin
    validPad                = '0;
    validPad[CHANNELS-1:0]  = bus.in_valid;
    grantValid              = 1'b0;
    grantIdx                = '0;
    probe                   = '0;
    iSel                    = '0;
    qSel                    = '0;
    for (int off = 1; off <= CHANNELS; off++) begin
      probe = CW'((int'(ptr_q) + off) % CHANNELS);
      if (!grantValid && validPad[probe]) begin
        grantValid = 1'b1;
        grantIdx   = probe;
      end
    end
    for (int c = 0; c < CHANNELS; c++) begin
      if (grantIdx == CW'(c)) begin
        iSel = bus.in_i[8*c +: 8];
        qSel = bus.in_q[8*c +: 8];
      end
    end
  end

  // Next state, multiplier operand steering and result computation.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    ch_d     = ch_q;
    iCap_d   = iCap_q;
    qCap_d   = qCap_q;
    p1_d     = p1_q;
    m_d      = m_q;
    mChan_d  = mChan_q;
    mValid_d = 1'b0;
    mulA     = '0;
    mulB     = '0;
    histWr   = 1'b0;
    case (state_q)
      IDLE: begin
        if (grantValid) begin
          iCap_d  = iSel;
          qCap_d  = qSel;
          ch_d    = grantIdx;
          ptr_d   = grantIdx;
          state_d = MUL1;
        end
      end
      MUL1: begin
        mulA    = iCap_q;
        mulB    = qLast_q[ch_q];
        p1_d    = bus.mul_p;
        state_d = MUL2;
      end
      MUL2: begin
        mulA     = qCap_q;
        mulB     = iLast_q[ch_q];
        m_d      = p1_q - bus.mul_p;
        mChan_d  = ch_q;
        mValid_d = 1'b1;
        histWr   = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Accept strobe is one-hot at the grant while idle and held low in reset.
  always_comb begin
    readyVec = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      readyVec[c] = rst_n && (state_q == IDLE) && grantValid && (grantIdx == CW'(c));
    end
  end

  assign bus.in_ready = readyVec;
  assign bus.mul_a    = mulA;
  assign bus.mul_b    = mulB;
  assign bus.m        = m_q;
  assign bus.m_valid  = mValid_q;
  assign bus.m_chan   = mChan_q;

  // FSM state register; channel 0 wins first after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= CW'(CHANNELS - 1);
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // Captured sample, first partial product and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ch_q     <= '0;
      iCap_q   <= '0;
      qCap_q   <= '0;
      p1_q     <= '0;
      m_q      <= '0;
      mChan_q  <= '0;
      mValid_q <= 1'b0;
    end else begin
      ch_q     <= ch_d;
      iCap_q   <= iCap_d;
      qCap_q   <= qCap_d;
      p1_q     <= p1_d;
      m_q      <= m_d;
      mChan_q  <= mChan_d;
      mValid_q <= mValid_d;
    end
  end

  // Per-channel history; a same-edge sample write takes precedence over a clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < NPAD; c++) begin
        iLast_q[c] <= '0;
        qLast_q[c] <= '0;
      end
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (histWr && (ch_q == CW'(c))) begin
          iLast_q[c] <= iCap_q;
          qLast_q[c] <= qCap_q;
        end else if (bus.hist_clr[c]) begin
          iLast_q[c] <= '0;
          qLast_q[c] <= '0;
        end
      end
    end
  end
endmodule
